vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, 16/96/48, horizontal front porch / sync / back porch in pixel ticks.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, 10/2/33, vertical front porch / sync / back porch in lines.
REQ-005 Parameter CLK_DIV, 4, clk cycles per pixel tick; legal range 1..16.
REQ-006 Parameter SYNC_POL, 0, sync active level (0 = active-low).
REQ-007 Parameter PIPE_DEPTH, 2, pixel ticks of delay on the _d outputs; legal range 0..8.
REQ-008 clk  input  1  system clock; rst  input  1  synchronous, active-high reset.
REQ-009 run  input  1  high enables scanning; sampled only at the frame boundary.
REQ-010 pix_en  output  1  single-clk pixel-tick strobe.
REQ-011 h_cnt, v_cnt  output  10 each  current pixel column / line.
REQ-012 valid, hsync, vsync  output  1 each  active-area flag and sync levels, aligned to h_cnt/v_cnt.
REQ-013 line_start, frame_start  output  1 each  one-pix_en-wide strobes at h_cnt=0 and at (h_cnt,v_cnt)=(0,0).
REQ-014 frame_cnt  output  8  frames completed, modulo 256.
REQ-015 valid_d, hsync_d, vsync_d  output  1 each  valid/hsync/vsync delayed by PIPE_DEPTH pixel ticks, for alignment with pipelined pixel sources.

Function
REQ-016 Divider: pix_en SHALL be high for exactly one clk every CLK_DIV clks; CLK_DIV=1 holds it high continuously.
REQ-017 Counters SHALL advance only on clk edges where pix_en=1; h_cnt wraps H_TOTAL-1 -> 0 (H_TOTAL = sum of the four H parameters) and increments v_cnt; v_cnt wraps V_TOTAL-1 -> 0.
REQ-018 valid SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, registered in the same edge as the counters (zero-cycle skew to h_cnt/v_cnt).
REQ-019 hsync SHALL be SYNC_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync SHALL behave likewise on v_cnt with the V parameters; both are otherwise ~SYNC_POL.
REQ-020 FSM states: IDLE (counters held at 0, valid=0, syncs inactive) and SCAN.
REQ-021 IDLE->SCAN on the first pix_en with run=1; SCAN->IDLE only at the wrap from (H_TOTAL-1,V_TOTAL-1) with run=0; run dropping mid-frame SHALL NOT truncate the frame.
REQ-022 frame_cnt SHALL increment at each wrap to (0,0) in SCAN, wrapping 255->0.
REQ-023 The _d outputs SHALL form a PIPE_DEPTH-stage shift register clocked by pix_en; PIPE_DEPTH=0 makes them equal to the undelayed signals.
REQ-024 frame_start and line_start SHALL be asserted only in SCAN.

Reset
REQ-025 rst SHALL zero the divider, h_cnt, v_cnt, frame_cnt, pix_en, valid, valid_d, line_start and frame_start, drive hsync/hsync_d/vsync/vsync_d to ~SYNC_POL, and enter IDLE.
REQ-026 rst asserted mid-frame SHALL take effect on the next clk edge regardless of pix_en; the first pix_en SHALL occur CLK_DIV clks after rst deasserts.

Configuration
REQ-027 Macro VGA_DOUBLESCAN_EN: when defined, the block SHALL add outputs x_half and y_half (9 bits each) = h_cnt>>1 and v_cnt>>1, registered with the counters, so 320x240 sources can be scanned at 640x480; when undefined, these ports and their logic SHALL be absent.

Structure
REQ-028 The default 640x480@60 timing constants, the H_TOTAL/V_TOTAL derivation function and the FSM state typedef SHALL live in shared package vga_pkg.
REQ-029 The divider SHALL be the sub-module vga_pix_div (parameter CLK_DIV; outputs pix_en), which replaces the standalone clock divider as the pixel-rate source.

Verification
REQ-030 Defaults, rst 3 clks, run=1 -> first pix_en at clk 4 after rst release; one line = 800 pix_en; one frame = 525 lines = 1,680,000 clks.
REQ-031 Defaults -> hsync low exactly for h_cnt 656..751 and vsync low exactly for v_cnt 490..491; valid high for 307,200 ticks per frame.
REQ-032 run dropped at (h=100,v=200) -> frame completes, IDLE entered at wrap, frame_cnt incremented once, counters held at 0.
REQ-033 rst pulsed at (h=300,v=100) -> next clk: h_cnt=0, v_cnt=0, hsync=vsync=1, valid=0, frame_cnt=0.
REQ-034 PIPE_DEPTH=3, SYNC_POL=1, CLK_DIV=1 -> hsync_d rises exactly 3 clks after hsync; hsync high for h_cnt 656..751.
REQ-035 frame_cnt at 255 -> wraps to 0 at the next frame boundary; with VGA_DOUBLESCAN_EN, x_half=319 when h_cnt=639.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), line/frame length helper and FSM state type.
package vga_pkg;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int CLK_DIV_DEF    = 4;
  localparam int PIPE_DEPTH_DEF = 2;

  typedef logic [0:0] vga_state_t;
  localparam vga_state_t ST_IDLE = 1'b0;
  localparam vga_state_t ST_SCAN = 1'b1;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate strobe generator: pix_en is high for one clk out of every CLK_DIV clks.
module vga_pix_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_q, div_d;
  logic       pix_en_q, pix_en_d;

  // First strobe lands CLK_DIV clks after reset release; CLK_DIV=1 keeps it high.
  always_comb begin
    if (div_q == DIV_LAST) begin
      div_d    = '0;
      pix_en_d = 1'b1;
    end else begin
      div_d    = div_q + 4'd1;
      pix_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
    end
  end

  assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters, sync/valid flags, strobes and pixel-tick delayed copies.
// Define VGA_DOUBLESCAN_EN to add the x_half/y_half half-resolution coordinates.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FP       = H_FP_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BP       = H_BP_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FP       = V_FP_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BP       = V_BP_DEF,
  parameter int   CLK_DIV    = CLK_DIV_DEF,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt,
  output logic       valid_d,
  output logic       hsync_d,
  output logic       vsync_d,
`ifdef VGA_DOUBLESCAN_EN
  output logic [8:0] x_half,
  output logic [8:0] y_half,
`endif
  output vga_state_t state_dbg
);

  localparam int         H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int         V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       pix_tick;
  vga_state_t state_q, state_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [7:0] fc_q, fc_d;
  logic       vis_q, vis_d, hs_q, hs_d, vs_q, vs_d, ls_q, ls_d, fs_q, fs_d;
  logic       scan;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_tick)
  );

  // Flags are computed from the next counter values so they share the counters' edge.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    fc_d    = fc_q;
    vis_d   = vis_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    ls_d    = ls_q;
    fs_d    = fs_q;
    scan    = 1'b0;
    if (pix_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (run) state_d = ST_SCAN;
        end
        default: begin
          if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
              v_d  = '0;
              fc_d = fc_q + 8'd1;
              // run is only honoured here, so a frame is never cut short.
              if (!run) state_d = ST_IDLE;
            end else begin
              v_d = v_q + 10'd1;
            end
          end else begin
            h_d = h_q + 10'd1;
          end
        end
      endcase
      scan  = (state_d == ST_SCAN);
      vis_d = scan && (h_d < H_ACT) && (v_d < V_ACT);
      hs_d  = (scan && (h_d >= HS_START) && (h_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_d  = (scan && (v_d >= VS_START) && (v_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
      ls_d  = scan && (h_d == 10'd0);
      fs_d  = scan && (h_d == 10'd0) && (v_d == 10'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      fc_q    <= '0;
      vis_q   <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fc_q    <= fc_d;
      vis_q   <= vis_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

`ifdef VGA_DOUBLESCAN_EN
  logic [8:0] xh_q, xh_d, yh_q, yh_d;

  always_comb begin
    xh_d = xh_q;
    yh_d = yh_q;
    if (pix_tick) begin
      xh_d = h_d[9:1];
      yh_d = v_d[9:1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xh_q <= '0;
      yh_q <= '0;
    end else begin
      xh_q <= xh_d;
      yh_q <= yh_d;
    end
  end

  assign x_half = xh_q;
  assign y_half = yh_q;
`endif

  generate
    if (PIPE_DEPTH == 0) begin : g_nopipe
      assign valid_d = vis_q;
      assign hsync_d = hs_q;
      assign vsync_d = vs_q;
    end else begin : g_pipe
      logic [PIPE_DEPTH-1:0] vp_q, vp_d, hp_q, hp_d, sp_q, sp_d;

      always_comb begin
        vp_d = vp_q;
        hp_d = hp_q;
        sp_d = sp_q;
        if (pix_tick) begin
          vp_d[0] = vis_q;
          hp_d[0] = hs_q;
          sp_d[0] = vs_q;
          for (int i = 1; i < PIPE_DEPTH; i++) begin
            vp_d[i] = vp_q[i-1];
            hp_d[i] = hp_q[i-1];
            sp_d[i] = sp_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          vp_q <= '0;
          hp_q <= {PIPE_DEPTH{~SYNC_POL}};
          sp_q <= {PIPE_DEPTH{~SYNC_POL}};
        end else begin
          vp_q <= vp_d;
          hp_q <= hp_d;
          sp_q <= sp_d;
        end
      end

      assign valid_d = vp_q[PIPE_DEPTH-1];
      assign hsync_d = hp_q[PIPE_DEPTH-1];
      assign vsync_d = sp_q[PIPE_DEPTH-1];
    end
  endgenerate

  assign pix_en      = pix_tick;
  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign valid       = vis_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small-geometry instances A (CLK_DIV=2) and B (CLK_DIV=1, PIPE 3, active-high
// sync) plus a default-parameter instance C for 640x480 line timing.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Pipelined {valid,hsync,vsync} expected for instance A.
  logic [2:0] exp_q[$];

  logic       rst_a = 1'b1, run_a = 1'b0;
  logic       rst_b = 1'b1, run_b = 1'b0;
  logic       rst_c = 1'b1, run_c = 1'b0;

  logic       pix_en_a, valid_a, hsync_a, vsync_a, ls_a, fs_a, valid_d_a, hsync_d_a, vsync_d_a;
  logic [9:0] h_a, v_a;
  logic [7:0] fc_a;
  vga_state_t st_a;
  logic       pix_en_b, valid_b, hsync_b, vsync_b, ls_b, fs_b, valid_d_b, hsync_d_b, vsync_d_b;
  logic [9:0] h_b, v_b;
  logic [7:0] fc_b;
  vga_state_t st_b;
  logic       pix_en_c, valid_c, hsync_c, vsync_c, ls_c, fs_c, valid_d_c, hsync_d_c, vsync_d_c;
  logic [9:0] h_c, v_c;
  logic [7:0] fc_c;
  vga_state_t st_c;
`ifdef VGA_DOUBLESCAN_EN
  logic [8:0] xh_a, yh_a, xh_b, yh_b, xh_c, yh_c;
`endif

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .SYNC_POL(1'b0), .PIPE_DEPTH(2)
  ) u_a (
    .clk(clk), .rst(rst_a), .run(run_a), .pix_en(pix_en_a), .h_cnt(h_a), .v_cnt(v_a),
    .valid(valid_a), .hsync(hsync_a), .vsync(vsync_a), .line_start(ls_a), .frame_start(fs_a),
    .frame_cnt(fc_a), .valid_d(valid_d_a), .hsync_d(hsync_d_a), .vsync_d(vsync_d_a),
`ifdef VGA_DOUBLESCAN_EN
    .x_half(xh_a), .y_half(yh_a),
`endif
    .state_dbg(st_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .SYNC_POL(1'b1), .PIPE_DEPTH(3)
  ) u_b (
    .clk(clk), .rst(rst_b), .run(run_b), .pix_en(pix_en_b), .h_cnt(h_b), .v_cnt(v_b),
    .valid(valid_b), .hsync(hsync_b), .vsync(vsync_b), .line_start(ls_b), .frame_start(fs_b),
    .frame_cnt(fc_b), .valid_d(valid_d_b), .hsync_d(hsync_d_b), .vsync_d(vsync_d_b),
`ifdef VGA_DOUBLESCAN_EN
    .x_half(xh_b), .y_half(yh_b),
`endif
    .state_dbg(st_b)
  );

  vga_timing_gen u_c (
    .clk(clk), .rst(rst_c), .run(run_c), .pix_en(pix_en_c), .h_cnt(h_c), .v_cnt(v_c),
    .valid(valid_c), .hsync(hsync_c), .vsync(vsync_c), .line_start(ls_c), .frame_start(fs_c),
    .frame_cnt(fc_c), .valid_d(valid_d_c), .hsync_d(hsync_d_c), .vsync_d(vsync_d_c),
`ifdef VGA_DOUBLESCAN_EN
    .x_half(xh_c), .y_half(yh_c),
`endif
    .state_dbg(st_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic pe(input int which);
    case (which)
      0:       return pix_en_a;
      1:       return pix_en_b;
      default: return pix_en_c;
    endcase
  endfunction

  // Advance exactly one pixel tick of the selected instance; returns at a negedge.
  task automatic tick(input int which);
    int n;
    n = 0;
    while (pe(which) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("tick_timeout", 32'(n), 0);
    @(negedge clk);
  endtask

  // Hand-derived waveform of instance A (15 ticks/line, 8 lines/frame).
  function automatic logic [2:0] a_flags(input int t);
    int h, v;
    logic vld, hs, vs;
    h   = t % 15;
    v   = t / 15;
    vld = (h < 8) && (v < 4);
    hs  = (h >= 10 && h <= 12) ? 1'b0 : 1'b1;
    vs  = (v >= 5 && v <= 6) ? 1'b0 : 1'b1;
    return {vld, hs, vs};
  endfunction

  initial begin
    int n, n_hs, n_hsd, h_rise, h_fall, cyc0, vcnt, hs_cnt, hs_min, hs_max, hi;
    logic [2:0] ef, ed;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_h", 32'(h_a), 0);
    check("rst_v", 32'(v_a), 0);
    check("rst_fc", 32'(fc_a), 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_hsync", 32'(hsync_a), 1);
    check("rst_vsync", 32'(vsync_a), 1);
    check("rst_hsync_d", 32'(hsync_d_a), 1);
    check("rst_valid_d", 32'(valid_d_a), 0);
    check("rst_pix_en", 32'(pix_en_a), 0);
    check("rst_fs", 32'(fs_a), 0);
    check("rst_ls", 32'(ls_a), 0);
    check("rst_state", 32'(st_a), 32'(ST_IDLE));
    check("rst_b_hsync", 32'(hsync_b), 0);
    check("rst_b_vsync_d", 32'(vsync_d_b), 0);

    // ---------------- C: default 640x480 line timing ----------------
    rst_c = 1'b0;
    run_c = 1'b1;
    n = 0;
    while (pix_en_c !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("c_first_pix_en_clks", 32'(n), 4);
    tick(2);
    check("c_scan_entry", 32'(st_c), 32'(ST_SCAN));
    check("c_fs_entry", 32'(fs_c), 1);
    cyc0 = cyc;
    vcnt = 0; hs_cnt = 0; hs_min = 9999; hs_max = -1;
    for (int t = 0; t < 800; t++) begin
      if (valid_c === 1'b1) vcnt++;
      if (hsync_c === 1'b0) begin
        hs_cnt++;
        hi = int'(h_c);
        if (hi < hs_min) hs_min = hi;
        if (hi > hs_max) hs_max = hi;
      end
`ifdef VGA_DOUBLESCAN_EN
      if (h_c == 10'd639) begin
        check("c_x_half_639", 32'(xh_c), 319);
        check("c_y_half_0", 32'(yh_c), 0);
      end
`endif
      tick(2);
    end
    check("c_line_clks", 32'(cyc - cyc0), 3200);
    check("c_line_h", 32'(h_c), 0);
    check("c_line_v", 32'(v_c), 1);
    check("c_line_ls", 32'(ls_c), 1);
    check("c_valid_per_line", 32'(vcnt), 640);
    check("c_hs_low_count", 32'(hs_cnt), 96);
    check("c_hs_low_first", 32'(hs_min), 656);
    check("c_hs_low_last", 32'(hs_max), 751);
    check("c_vsync_line1", 32'(vsync_c), 1);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (pix_en_c === 1'b1) n++;
    end
    check("c_pix_en_duty", 32'(n), 4);

    // ---------------- A: full frame with delayed outputs ----------------
    rst_a = 1'b0;
    run_a = 1'b1;
    tick(0);
    exp_q.push_back(3'b011);
    exp_q.push_back(3'b011);
    for (int t = 0; t < 120; t++) begin
      ef = a_flags(t);
      ed = exp_q.pop_front();
      exp_q.push_back(ef);
      check($sformatf("a_h t=%0d", t), 32'(h_a), t % 15);
      check($sformatf("a_v t=%0d", t), 32'(v_a), t / 15);
      check($sformatf("a_valid t=%0d", t), 32'(valid_a), 32'(ef[2]));
      check($sformatf("a_hsync t=%0d", t), 32'(hsync_a), 32'(ef[1]));
      check($sformatf("a_vsync t=%0d", t), 32'(vsync_a), 32'(ef[0]));
      check($sformatf("a_ls t=%0d", t), 32'(ls_a), (t % 15 == 0) ? 1 : 0);
      check($sformatf("a_fs t=%0d", t), 32'(fs_a), (t == 0) ? 1 : 0);
      check($sformatf("a_fc t=%0d", t), 32'(fc_a), 0);
      check($sformatf("a_pipe_d t=%0d", t), 32'({valid_d_a, hsync_d_a, vsync_d_a}), 32'(ed));
      tick(0);
    end
    check("a_wrap_h", 32'(h_a), 0);
    check("a_wrap_v", 32'(v_a), 0);
    check("a_wrap_fc", 32'(fc_a), 1);
    check("a_wrap_fs", 32'(fs_a), 1);

    // ---------------- A: run dropped mid-frame at (5,2) ----------------
    for (int t = 0; t < 120; t++) begin
      check($sformatf("a2_state t=%0d", t), 32'(st_a), 32'(ST_SCAN));
      check($sformatf("a2_h t=%0d", t), 32'(h_a), t % 15);
      check($sformatf("a2_v t=%0d", t), 32'(v_a), t / 15);
      if (t == 35) run_a = 1'b0;
      tick(0);
    end
    check("a_stop_state", 32'(st_a), 32'(ST_IDLE));
    check("a_stop_h", 32'(h_a), 0);
    check("a_stop_v", 32'(v_a), 0);
    check("a_stop_fc", 32'(fc_a), 2);
    check("a_stop_valid", 32'(valid_a), 0);
    check("a_stop_hsync", 32'(hsync_a), 1);
    check("a_stop_fs", 32'(fs_a), 0);
    check("a_stop_ls", 32'(ls_a), 0);
    repeat (3) tick(0);
    check("a_idle_state", 32'(st_a), 32'(ST_IDLE));
    check("a_idle_h", 32'(h_a), 0);
    check("a_idle_fc", 32'(fc_a), 2);

    // ---------------- A: reset mid-frame at (7,3), pix_en low ----------------
    run_a = 1'b1;
    tick(0);
    check("a_restart_fs", 32'(fs_a), 1);
    repeat (52) tick(0);
    check("a_pre_rst_h", 32'(h_a), 7);
    check("a_pre_rst_v", 32'(v_a), 3);
    check("a_pre_rst_pix_en", 32'(pix_en_a), 0);
    rst_a = 1'b1;
    @(negedge clk);
    check("a_mrst_h", 32'(h_a), 0);
    check("a_mrst_v", 32'(v_a), 0);
    check("a_mrst_hsync", 32'(hsync_a), 1);
    check("a_mrst_vsync", 32'(vsync_a), 1);
    check("a_mrst_valid", 32'(valid_a), 0);
    check("a_mrst_valid_d", 32'(valid_d_a), 0);
    check("a_mrst_fc", 32'(fc_a), 0);
    check("a_mrst_state", 32'(st_a), 32'(ST_IDLE));
    rst_a = 1'b0;
    run_a = 1'b0;

    // ---------------- B: CLK_DIV=1, PIPE_DEPTH=3, SYNC_POL=1 ----------------
    rst_b = 1'b0;
    run_b = 1'b1;
    n = 0; n_hs = -1; n_hsd = -1; h_rise = -1; h_fall = -1;
    while ((n_hsd < 0 || h_fall < 0) && n < 200) begin
      @(negedge clk);
      n++;
      if (n_hs < 0 && hsync_b === 1'b1) begin
        n_hs   = n;
        h_rise = int'(h_b);
      end
      if (n_hs >= 0 && h_fall < 0 && hsync_b === 1'b0) h_fall = int'(h_b);
      if (n_hsd < 0 && hsync_d_b === 1'b1) n_hsd = n;
    end
    check("b_hs_rise_h", 32'(h_rise), 10);
    check("b_hs_fall_h", 32'(h_fall), 13);
    check("b_hsd_lag_clks", 32'(n_hsd - n_hs), 3);

    n = 0;
    while (fc_b !== 8'd255 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check("b_fc_reach_255", 32'(fc_b), 255);
    check("b_fc255_fs", 32'(fs_b), 1);
    n = 0;
    while (fc_b === 8'd255 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_fc_frame_clks", 32'(n), 120);
    check("b_fc_wrap", 32'(fc_b), 0);
    check("b_fc_wrap_h", 32'(h_b), 0);
    check("b_fc_wrap_v", 32'(v_b), 0);
    check("b_fc_wrap_fs", 32'(fs_b), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
